// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Types and constants shared by the PS/2 host transmitter and keyboard receiver.
//   ps2_state_e  : host-to-device transmit FSM states
//   CMD_*        : host command bytes sent to the keyboard
//   RSP_*        : keyboard reply bytes
//   odd_parity() : PS/2 frame parity bit for a data byte
// -----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings the raw ps2_clk / ps2_data pin levels into the clk domain through
// 2-flop synchronisers and flags edges on the synchronised clock line.
//   clk, reset  : system clock, asynchronous active-high reset
//   ps2_clk_i   : raw ps2_clk pin level
//   ps2_data_i  : raw ps2_data pin level
//   clk_s       : synchronised ps2_clk
//   data_s      : synchronised ps2_data
//   fall        : one-cycle flag, synchronised ps2_clk went 1 -> 0
//   rise        : one-cycle flag, synchronised ps2_clk went 0 -> 1
// -----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall,
  output logic rise
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Reset to 1: an idle open-drain bus floats high, so no false edge on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is exactly what turns this chain into a shift register.
      clk_meta  <= ps2_clk_i;
      clk_s     <= clk_meta;
      clk_prev  <= clk_s;
      data_meta <= ps2_data_i;
      data_s    <= data_meta;
    end
  end

  assign fall = clk_prev & ~clk_s;
  assign rise = ~clk_prev & clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts out 8 data bits (LSB first), odd parity and a stop bit on the
// device-generated clock, and finally checks the device's ack bit.
//   clk, reset   : system clock (pclk), asynchronous active-high reset
//   tx_data      : command byte
//   tx_valid     : request to send tx_data (ignored unless tx_ready)
//   tx_ready     : high only when idle
//   tx_done      : one-cycle pulse, frame acknowledged by the device
//   tx_error     : one-cycle pulse, watchdog timeout or missing ack
//   busy         : high whenever a transmission is in progress
//   ps2_clk_i    : raw ps2_clk pin level
//   ps2_data_i   : raw ps2_data pin level
//   ps2_clk_oe   : 1 = pull ps2_clk low, 0 = release
//   ps2_data_oe  : 1 = pull ps2_data low, 0 = release
// -----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2440,
  parameter int unsigned TIMEOUT_CYCLES = 48800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned MAX_CYCLES =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW = $clog2(MAX_CYCLES) + 1;
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s;
  logic data_s;
  logic fall;
  logic rise;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .fall       (fall),
    .rise       (rise)
  );

  ps2_state_e    state;
  logic [7:0]    shreg;
  logic          parity;
  logic [3:0]    bit_cnt;   // data bits already driven onto the bus
  logic [TW-1:0] timer;     // inhibit length in INHIBIT, watchdog afterwards
  logic          ack_ok;

  logic          watched;   // watchdog armed in this state
  logic          activity;  // device edge that restarts the watchdog

  // The device clock idles high for half a bit time between falls, so any
  // device edge restarts the watchdog. In REQ the only rise is the echo of
  // releasing our own inhibit, so there only a fall counts.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // assignment in some branch would otherwise infer a latch.
    watched  = 1'b0;
    activity = 1'b0;
    case (state)
      ST_REQ: begin
        watched  = 1'b1;
        activity = fall;
      end
      ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE: begin
        watched  = 1'b1;
        activity = fall | rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      parity      <= 1'b0;
      bit_cnt     <= '0;
      timer       <= '0;
      ack_ok      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      // Watchdog. A fall in the expiry cycle counts as activity, so it wins;
      // the state case below overrides the abort when the frame completes.
      if (watched) begin
        if (activity) begin
          timer <= '0;
        end else if (timer == TIMEOUT_LAST) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_error    <= 1'b1;
          busy        <= 1'b0;
          tx_ready    <= 1'b1;
          timer       <= '0;
          state       <= ST_IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg       <= tx_data;
            parity      <= odd_parity(tx_data);
            bit_cnt     <= '0;
            timer       <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b1;
            tx_ready    <= 1'b0;
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            // Release clk and pull data low in the same edge: the start bit.
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            timer       <= '0;
            state       <= ST_REQ;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_REQ: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b0, shreg[7:1]};
            bit_cnt     <= 4'd1;
            state       <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (fall) begin
            if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~parity;
              state       <= ST_PARITY;
            end else begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[7:1]};
              bit_cnt     <= bit_cnt + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (fall) begin
            ps2_data_oe <= 1'b0;   // released line is the stop bit
            state       <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (fall) begin
            ack_ok <= ~data_s;     // device pulls data low to acknowledge
            state  <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            tx_done  <= ack_ok;
            tx_error <= ~ack_ok;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64.
// A behavioural keyboard drives the open-drain bus with 40-cycle clock
// half-periods, samples host data on its rising edges and pulls data low
// for the ack.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int total = 0;
  int bad = 0;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .busy        (busy),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Pulse / handshake monitor, sampled on the inactive edge.
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   acc_cnt = 0;
  int   clash_cnt = 0;
  logic done_busy = 1'b0;
  logic err_busy = 1'b0;
  logic err_idle = 1'b0;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt  <= done_cnt + 1;
      done_busy <= busy;
    end
    if (tx_error) begin
      err_cnt  <= err_cnt + 1;
      err_busy <= busy;
      err_idle <= ps2_clk_line & ps2_data_line;
    end
    if (tx_valid && tx_ready && !reset) acc_cnt <= acc_cnt + 1;
    if (ps2_clk_oe && ps2_data_oe) clash_cnt <= clash_cnt + 1;
  end

  // Present one byte for exactly one accepting clock edge.
  task automatic send_start(input logic [7:0] b);
    @(posedge clk); #2;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
  endtask

  // Keyboard model. bits[0]=start, bits[8:1]=byte, bits[9]=parity,
  // bits[10]=stop. stop_after>0 abandons the frame after that many falls,
  // leaving the clock held low.
  task automatic device_frame(input bit give_ack, input int stop_after,
                              output logic [10:0] bits, output int inh,
                              output bit ok);
    int n;
    bits = '0;
    inh  = 0;
    ok   = 1'b0;
    @(negedge clk);
    n = 0;
    while (!ps2_clk_oe && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ps2_clk_oe) return;
    while (ps2_clk_oe && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    n = 0;
    while (!(ps2_clk_line && !ps2_data_line) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(ps2_clk_line && !ps2_data_line)) return;
    ok = 1'b1;
    repeat (10) @(negedge clk);
    bits[0] = ps2_data_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == stop_after) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[i] = ps2_data_line;
      repeat (20) @(negedge clk);
      if (i == 10 && give_ack) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (40) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = tx_ready;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 6;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    if (tx_error !== 1'b0) begin bad++; $display("FAIL reset_tx_error got=%b want=0", tx_error); end
    if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b want=0", ps2_clk_oe); end
    if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b want=0", ps2_data_oe); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_send_leds();
    logic [10:0] bits;
    int inh;
    bit ok, idle_ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_start(CMD_SET_LEDS);
    device_frame(1'b1, 0, bits, inh, ok);
    wait_idle(idle_ok);
    total += 9;
    if (!(ok && idle_ok)) begin bad++; $display("FAIL leds_handshake got ok=%b idle=%b want 1 1", ok, idle_ok); end
    if (inh !== 8) begin bad++; $display("FAIL leds_inhibit_len got=%0d want=8", inh); end
    if (bits[0] !== 1'b0) begin bad++; $display("FAIL leds_start got=%b want=0", bits[0]); end
    if (bits[8:1] !== 8'b1110_1101) begin bad++; $display("FAIL leds_byte got=%h want=ed", bits[8:1]); end
    if (bits[10:9] !== 2'b11) begin bad++; $display("FAIL leds_parity_stop got=%b want=11", bits[10:9]); end
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL leds_done_pulses got=%0d want=1", done_cnt - d0); end
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL leds_error_pulses got=%0d want=0", err_cnt - e0); end
    if (done_busy !== 1'b0) begin bad++; $display("FAIL leds_busy_at_done got=%b want=0", done_busy); end
    if (busy !== 1'b0) begin bad++; $display("FAIL leds_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_parity();
    logic [10:0] bits_a, bits_b;
    int inh;
    bit ok_a, ok_b, idle_a, idle_b;
    int d0 = done_cnt;
    send_start(8'h00);
    device_frame(1'b1, 0, bits_a, inh, ok_a);
    wait_idle(idle_a);
    send_start(8'h01);
    device_frame(1'b1, 0, bits_b, inh, ok_b);
    wait_idle(idle_b);
    total += 4;
    if (!(ok_a && ok_b && idle_a && idle_b)) begin bad++; $display("FAIL parity_handshake got=%b%b%b%b want=1111", ok_a, ok_b, idle_a, idle_b); end
    if (bits_a !== 11'b1_1_00000000_0) begin bad++; $display("FAIL parity_00_frame got=%b want=11000000000", bits_a); end
    if (bits_b !== 11'b1_0_00000001_0) begin bad++; $display("FAIL parity_01_frame got=%b want=10000000010", bits_b); end
    if (done_cnt - d0 !== 2) begin bad++; $display("FAIL parity_done_pulses got=%0d want=2", done_cnt - d0); end
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    int inh;
    bit ok, idle_ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_start(CMD_RESET);
    device_frame(1'b0, 0, bits, inh, ok);
    wait_idle(idle_ok);
    total += 6;
    if (!(ok && idle_ok)) begin bad++; $display("FAIL noack_handshake got ok=%b idle=%b want 1 1", ok, idle_ok); end
    if (bits !== 11'b1_1_11111111_0) begin bad++; $display("FAIL noack_frame got=%b want=11111111110", bits); end
    if (err_cnt - e0 !== 1) begin bad++; $display("FAIL noack_error_pulses got=%0d want=1", err_cnt - e0); end
    if (done_cnt - d0 !== 0) begin bad++; $display("FAIL noack_done_pulses got=%0d want=0", done_cnt - d0); end
    if (err_idle !== 1'b1) begin bad++; $display("FAIL noack_lines_idle got=%b want=1", err_idle); end
    if (err_busy !== 1'b0) begin bad++; $display("FAIL noack_busy_at_error got=%b want=0", err_busy); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int d0 = done_cnt;
    send_start(CMD_ENABLE);
    @(negedge clk);
    while (!ps2_data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    total += 1;
    if (!ps2_data_oe) begin
      bad++;
      $display("FAIL timeout_req got data_oe=%b want=1", ps2_data_oe);
    end else begin
      n = 0;
      while (!tx_error && n < 200) begin
        @(negedge clk);
        n++;
      end
      total += 4;
      if (n !== 64) begin bad++; $display("FAIL timeout_cycles got=%0d want=64", n); end
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL timeout_oe got=%b want=00", {ps2_clk_oe, ps2_data_oe}); end
      if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
      @(negedge clk);
      if ({tx_ready, tx_error} !== 2'b10) begin bad++; $display("FAIL timeout_ready_next got=%b want=10", {tx_ready, tx_error}); end
    end
    repeat (3) @(negedge clk);
    #1;
    total += 1;
    if (done_cnt - d0 !== 0) begin bad++; $display("FAIL timeout_done_pulses got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    int inh;
    bit ok, idle_ok;
    int d0 = done_cnt, e0 = err_cnt;
    send_start(CMD_SET_LEDS);
    device_frame(1'b1, 4, bits, inh, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL midrst_handshake got=%b want=1", ok); end
    if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    #2;
    reset = 1'b1;
    #1;
    total += 2;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL midrst_oe_async got=%b want=00", {ps2_clk_oe, ps2_data_oe}); end
    if ({tx_ready, busy} !== 2'b10) begin bad++; $display("FAIL midrst_ready_busy got=%b want=10", {tx_ready, busy}); end
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total += 1;
    if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", (done_cnt - d0) + (err_cnt - e0)); end
    send_start(CMD_ENABLE);
    device_frame(1'b1, 0, bits, inh, ok);
    wait_idle(idle_ok);
    total += 3;
    if (!(ok && idle_ok)) begin bad++; $display("FAIL midrst_resend_handshake got ok=%b idle=%b want 1 1", ok, idle_ok); end
    if (bits !== 11'b1_0_11110100_0) begin bad++; $display("FAIL midrst_f4_frame got=%b want=10111101000", bits); end
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL midrst_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic hold_then_drop();
    int n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    tx_data = CMD_RESET;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits_a, bits_b;
    int inh;
    bit ok_a, ok_b, idle_ok;
    int d0 = done_cnt, a0 = acc_cnt;
    @(posedge clk); #2;
    tx_data  = CMD_SET_LEDS;
    tx_valid = 1'b1;
    fork
      begin
        device_frame(1'b1, 0, bits_a, inh, ok_a);
        device_frame(1'b1, 0, bits_b, inh, ok_b);
      end
      hold_then_drop();
    join
    tx_valid = 1'b0;
    wait_idle(idle_ok);
    total += 5;
    if (!(ok_a && ok_b && idle_ok)) begin bad++; $display("FAIL b2b_handshake got=%b%b%b want=111", ok_a, ok_b, idle_ok); end
    if (bits_a !== 11'b1_1_11101101_0) begin bad++; $display("FAIL b2b_first_frame got=%b want=11111011010", bits_a); end
    if (bits_b !== 11'b1_1_11111111_0) begin bad++; $display("FAIL b2b_second_frame got=%b want=11111111110", bits_b); end
    if (acc_cnt - a0 !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d want=2", acc_cnt - a0); end
    if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_send_leds();
    test_parity();
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    total += 1;
    if (clash_cnt !== 0) begin bad++; $display("FAIL line_contention got=%0d want=0", clash_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
